ro_freq_counter: RTL and testbench
==================================

// Module: ro_freq_counter
// PURPOSE
//  Measurement stage directly downstream of a ring-oscillator sensor cell.
//  Drives the cell's enable and counts rising edges of its free-running output over a
//  programmable gate window of system-clock cycles. The count is the oscillator's
//  frequency/delay metric, read by the register interface for reliability/ageing tracking.
//  Sampling is single-clock (synchronise, then edge-detect).
//  Usable range: f_ro < f_clk/2. Faster cells need an external prescaler.
// PARAMETERS
//  CNT_W         32  width of edge counter and result
//  GATE_W        24  width of gate_cycles (measurement window length)
//  SETTLE_CYCLES 16  clk cycles ro_en is held high before counting starts (>=1)
//  SYNC_STAGES    2  flip-flops in ro_clk synchroniser (>=2)
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  rst          in   1       asynchronous, active-high reset
//  start        in   1       1-cycle request to begin a measurement; honoured only in IDLE
//  abort        in   1       cancel the measurement in progress; return to IDLE
//  gate_cycles  in   GATE_W  window length in clk cycles; latched when start is accepted
//  ro_en        out  1       enable to ring oscillator; high in SETTLE and MEASURE only
//  ro_clk       in   1       oscillator output; asynchronous to clk
//  busy         out  1       high in SETTLE and MEASURE
//  done         out  1       1-cycle pulse when result is updated
//  count        out  CNT_W   last completed result; held until next done
//  overflow     out  1       last result saturated; updates with count
// BEHAVIOUR
//  Reset: state=IDLE, ro_en=0, busy=0, done=0, count=0, overflow=0.
//   Synchroniser, edge history and internal counters are cleared.
//  Synchroniser runs in every state: ro_clk -> SYNC_STAGES FFs -> s. Keep prev=s each cycle.
//   rise = s & ~prev.
//  FSM states: IDLE, SETTLE, MEASURE, DONE.
//   IDLE: start=1 and gate_cycles!=0 -> latch gate, go to SETTLE.
//    start=1 and gate_cycles==0 -> go to DONE with result 0 and overflow 0.
//    In the zero-gate case ro_en is never raised.
//   SETTLE: ro_en=1 for exactly SETTLE_CYCLES cycles, then go to MEASURE.
//    Edge counter is 0 on the first MEASURE cycle.
//   MEASURE: ro_en=1. Every cycle with rise=1 increments the edge counter.
//    The counter saturates at all-ones and sets a sticky ovf bit.
//    Exactly gate cycles are sampled. On the last one (including its rise), go to DONE.
//   DONE (one cycle): ro_en=0, busy=0, done=1. count and overflow load the final value.
//    Next state is IDLE.
//  abort=1 in SETTLE or MEASURE: next cycle is IDLE with ro_en=0 and busy=0.
//   No done pulse; count and overflow unchanged.
//   abort in IDLE or DONE has no effect. abort has priority over the last-cycle transition.
//  start while busy or in DONE is ignored; it is not queued.
//  Latency: done asserts SETTLE_CYCLES+gate+1 cycles after the start cycle.
//  Result uncertainty is +/-1 edge (asynchronous phase) plus synchroniser delay.
//  Edges that occur up to SYNC_STAGES cycles after ro_en falls are not counted.
//  Reset mid-measurement: immediate return to reset values; ro_en drops asynchronously.
// TESTING
//  T1 ro_clk model = toggle every 2 clk (period 4 clk), SETTLE_CYCLES=16, gate=1000, pulse start
//     -> done 1017 cycles after start; count in {249,250,251}; overflow=0.
//  T2 gate_cycles=0, start -> ro_en stays 0; done on the cycle after start; count=0.
//  T3 CNT_W=4, period-4 ro_clk, gate=200 -> count=4'hF, overflow=1.
//     Then gate=20 -> count in {4,5,6}, overflow=0.
//  T4 abort 10 cycles into MEASURE -> IDLE next cycle, ro_en=0, no done, count keeps prior value.
//     A new start then completes normally.
//  T5 start pulsed again mid-MEASURE and in the DONE cycle -> ignored; exactly one done pulse.
//  T6 rst asserted mid-MEASURE, async to clk -> ro_en/busy/count/overflow=0 at once.
//     Post-reset T1 reproduces its count.

Source files
------------

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the sensor cell, waits for it to settle, and then
// counts the synchronised rising edges of ro_clk over a programmable window of clk cycles.
module ro_freq_counter #(
    parameter int unsigned CNT_W         = 32,
    parameter int unsigned GATE_W        = 24,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    output logic              ro_en,
    input  logic              ro_clk,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEASURE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   rise;
    logic [SET_W-1:0]       settle_cnt;
    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   ovf;
    logic [CNT_W-1:0]       edge_nxt;
    logic                   ovf_nxt;

    // The synchroniser and the edge history keep running in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], ro_clk};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign rise = sync[SYNC_STAGES-1] & ~prev;

    // The edge counter stops at all-ones. The sticky ovf bit records that it saturated.
    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf;
        if (rise) begin
            if (&edge_cnt) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            ovf        <= 1'b0;
            ro_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (gate_cycles != '0) begin
                            gate_cnt   <= gate_cycles - GATE_W'(1);
                            settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
                            ro_en      <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_SETTLE;
                        end else begin
                            count    <= '0;
                            overflow <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        ro_en <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (settle_cnt == '0) begin
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                        state    <= S_MEASURE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (abort) begin
                        ro_en <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        edge_cnt <= edge_nxt;
                        ovf      <= ovf_nxt;
                        // The last sampled cycle still counts its own edge.
                        if (gate_cnt == '0) begin
                            count    <= edge_nxt;
                            overflow <= ovf_nxt;
                            done     <= 1'b1;
                            ro_en    <= 1'b0;
                            busy     <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            gate_cnt <= gate_cnt - GATE_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Testbench for ro_freq_counter. A scoreboard records the expected result window and the
// expected latency of each accepted start, and checks them against every done pulse.
module tb_ro_freq_counter;

    localparam int unsigned SETTLE = 16;

    typedef struct {
        int unsigned lo;
        int unsigned hi;
        logic        ovf;
        int unsigned lat;
        int unsigned t0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ro_clk = 1'b0;
    logic        start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [23:0] gate_a = '0, gate_b = '0;
    logic        ro_en_a, busy_a, done_a, overflow_a;
    logic        ro_en_b, busy_b, done_b, overflow_b;
    logic [31:0] count_a;
    logic [3:0]  count_b;

    int unsigned cyc = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];

    ro_freq_counter #(.CNT_W(32), .GATE_W(24), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .gate_cycles(gate_a),
        .ro_en(ro_en_a), .ro_clk(ro_clk), .busy(busy_a), .done(done_a),
        .count(count_a), .overflow(overflow_a)
    );

    ro_freq_counter #(.CNT_W(4), .GATE_W(24), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .gate_cycles(gate_b),
        .ro_en(ro_en_b), .ro_clk(ro_clk), .busy(busy_b), .done(done_b),
        .count(count_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    // Oscillator period is 40 ns (4 clk periods), with a phase that is off the clk grid.
    initial begin
        #7;
        forever #20 ro_clk = ~ro_clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic score(input string tag, input int unsigned cnt, input logic ovf, input exp_t e);
        check({tag, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
        check($sformatf("%s_count(%0d in %0d..%0d)", tag, cnt, e.lo, e.hi),
              64'(cnt >= e.lo && cnt <= e.hi), 64'(1));
        check({tag, "_overflow"}, 64'(ovf), 64'(e.ovf));
    endtask

    // Each done pulse consumes one expected entry. A pulse with no entry pending is an error.
    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (q_a.size() == 0) check("A_unexpected_done", 64'(1), 64'(0));
            else begin
                e = q_a.pop_front();
                score("A", count_a, overflow_a, e);
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) check("B_unexpected_done", 64'(1), 64'(0));
            else begin
                e = q_b.pop_front();
                score("B", 32'(count_b), overflow_b, e);
            end
        end
    end

    // Called at a negedge. Drives a one-cycle start and records the expected result.
    task automatic start_meas(input bit sel, input int unsigned gate, input int unsigned lo,
                              input int unsigned hi, input logic ovf);
        exp_t e;
        e.lo  = lo;
        e.hi  = hi;
        e.ovf = ovf;
        e.lat = (gate == 0) ? 1 : SETTLE + gate + 1;
        e.t0  = cyc;
        if (sel) begin q_b.push_back(e); gate_b = 24'(gate); start_b = 1'b1; end
        else     begin q_a.push_back(e); gate_a = 24'(gate); start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Drives a start pulse that records no expected result.
    task automatic pulse_start(input bit sel, input int unsigned gate);
        if (sel) begin gate_b = 24'(gate); start_b = 1'b1; end
        else     begin gate_a = 24'(gate); start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget);
        int n = 0;
        while (((sel ? done_b : done_a) == 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if ((sel ? done_b : done_a) == 1'b0) check("done_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ro_en", 64'(ro_en_a), 64'(0));
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_done", 64'(done_a), 64'(0));
        check("rst_count", 64'(count_a), 64'(0));
        check("rst_overflow", 64'(overflow_a), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // A nominal 1000-cycle window at period 4 gives about 250 edges.
        start_meas(0, 1000, 249, 251, 1'b0);
        check("t1_busy", 64'(busy_a), 64'(1));
        check("t1_ro_en", 64'(ro_en_a), 64'(1));
        wait_done(0, 1100);
        @(negedge clk);

        // With a zero gate the block goes straight to DONE and never enables the cell.
        start_meas(0, 0, 0, 0, 1'b0);
        check("t2_ro_en_done_cycle", 64'(ro_en_a), 64'(0));
        check("t2_busy", 64'(busy_a), 64'(0));
        check("t2_done", 64'(done_a), 64'(1));
        @(negedge clk);
        check("t2_ro_en_after", 64'(ro_en_a), 64'(0));

        // A 4-bit counter saturates on 50 edges.
        start_meas(1, 200, 15, 15, 1'b1);
        wait_done(1, 300);
        @(negedge clk);

        // An abort in MEASURE returns to IDLE with no done, and the previous result is held.
        pulse_start(1, 1000);
        repeat (SETTLE + 10) @(negedge clk);
        check("t4_busy_measuring", 64'(busy_b), 64'(1));
        abort_b = 1'b1;
        @(negedge clk);
        abort_b = 1'b0;
        check("t4_busy", 64'(busy_b), 64'(0));
        check("t4_ro_en", 64'(ro_en_b), 64'(0));
        check("t4_count_held", 64'(count_b), 64'(4'hF));
        check("t4_overflow_held", 64'(overflow_b), 64'(1));
        repeat (5) @(negedge clk);
        start_meas(1, 20, 4, 6, 1'b0);
        wait_done(1, 100);
        @(negedge clk);

        // Start pulses seen while busy or in the DONE cycle are ignored.
        start_meas(0, 100, 24, 26, 1'b0);
        repeat (60) @(negedge clk);
        pulse_start(0, 5);
        wait_done(0, 200);
        pulse_start(0, 5);
        check("t5_not_restarted", 64'(busy_a), 64'(0));
        repeat (30) @(negedge clk);
        check("t5_queue_empty", 64'(q_a.size()), 64'(0));

        // An asynchronous reset in MEASURE clears the outputs immediately.
        pulse_start(0, 1000);
        repeat (500) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_ro_en", 64'(ro_en_a), 64'(0));
        check("t6_busy", 64'(busy_a), 64'(0));
        check("t6_count", 64'(count_a), 64'(0));
        check("t6_overflow", 64'(overflow_a), 64'(0));
        check("t6_b_count", 64'(count_b), 64'(0));
        q_a.delete();
        q_b.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_meas(0, 1000, 249, 251, 1'b0);
        wait_done(0, 1100);
        repeat (3) @(negedge clk);

        check("final_queue_a", 64'(q_a.size()), 64'(0));
        check("final_queue_b", 64'(q_b.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
